// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared state type and frame sizing for the serial link blocks
// Defining PISO_PARITY_EN appends one even-parity bit to every frame.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - loadable up-counter with a terminal-count flag
module bit_counter #(
  parameter int CW   = 4,
  parameter int TERM = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] TERM_V = CW'(TERM);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == TERM_V);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with valid/ready load and framing strobe
// Build with PISO_PARITY_EN to send an even-parity bit after the data bits.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW        = cnt_width(WIDTH);
  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    count;
  logic             tc;
  logic             accept;
  logic             data_done;
  logic             head;

  // The counter runs across the whole frame, so its terminal value marks ser_last.
  bit_counter #(
    .CW  (CW),
    .TERM(FRAME_LEN - 1)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept || ser_last),
    .load_val('0),
    .en      (state_q != IDLE),
    .count   (count),
    .tc      (tc)
  );

  assign busy       = (state_q != IDLE);
  assign ser_valid  = busy;
  assign ser_last   = busy && tc;
  assign load_ready = (state_q == IDLE) || ser_last;
  assign accept     = load_valid && load_ready;
  assign data_done  = (state_q == SHIFT) && (count == LAST_DATA);

  assign head          = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
  logic parity_d, parity_q;

  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
      end
      SHIFT: begin
        shreg_d = shreg_shifted;
        if (data_done) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
      PARITY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A word accepted on the last bit starts the next frame with no gap.
    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    ser_out = 1'b0;
    if (state_q == SHIFT) begin
      ser_out = head;
    end
`ifdef PISO_PARITY_EN
    else if (state_q == PARITY) begin
      ser_out = parity_q;
    end
`endif
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer, LSB-first and MSB-first instances
// Honours PISO_PARITY_EN for the expected frame length and parity bit.
`timescale 1ns/1ps
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] ld_data  [2];
  logic         ld_valid [2];
  logic         ld_ready [2];
  logic         so       [2];
  logic         sv       [2];
  logic         sl       [2];
  logic         bz       [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_data(ld_data[0]), .load_valid(ld_valid[0]),
    .load_ready(ld_ready[0]), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_data(ld_data[1]), .load_valid(ld_valid[1]),
    .load_ready(ld_ready[1]), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1])
  );

  // Bit at frame position i: data bits in wire order, then the even-parity bit.
  function automatic logic exp_bit(input int sel, input logic [W-1:0] w, input int i);
    if (i >= W) return ^w;
    return (sel == 1) ? w[W-1-i] : w[i];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    ld_valid[0] = 1'b1; ld_data[0] = 8'h3C;
    ld_valid[1] = 1'b1; ld_data[1] = 8'hC3;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (sv[s] !== 1'b0 || bz[s] !== 1'b0 || so[s] !== 1'b0 || sl[s] !== 1'b0 || ld_ready[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_immediate dut%0d: valid=%b busy=%b out=%b last=%b ready=%b, required 0 0 0 0 1",
                 s, sv[s], bz[s], so[s], sl[s], ld_ready[s]);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (bz[s] !== 1'b0 || sv[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_load_ignored dut%0d: busy=%b valid=%b, required 0 0", s, bz[s], sv[s]);
      end
      ld_valid[s] = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (bz[s] !== 1'b0 || ld_ready[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release dut%0d: busy=%b ready=%b, required 0 1", s, bz[s], ld_ready[s]);
      end
    end
  endtask

  task automatic test_single_frame(input int sel, input logic [W-1:0] w);
    @(negedge clk);
    checks++;
    if (ld_ready[sel] !== 1'b1) begin
      errors++;
      $display("FAIL frame_ready dut%0d word=%h: ready=%b, required 1", sel, w, ld_ready[sel]);
    end
    ld_data[sel]  = w;
    ld_valid[sel] = 1'b1;
    @(negedge clk);
    ld_valid[sel] = 1'b0;
    ld_data[sel]  = W'($urandom);
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (sv[sel] !== 1'b1 || bz[sel] !== 1'b1 || so[sel] !== exp_bit(sel, w, i) || sl[sel] !== (i == FL - 1)) begin
        errors++;
        $display("FAIL frame_bit dut%0d word=%h bit%0d: valid=%b busy=%b out=%b last=%b, required 1 1 %b %b",
                 sel, w, i, sv[sel], bz[sel], so[sel], sl[sel], exp_bit(sel, w, i), (i == FL - 1));
      end
      @(negedge clk);
    end
    checks++;
    if (sv[sel] !== 1'b0 || bz[sel] !== 1'b0 || sl[sel] !== 1'b0 || so[sel] !== 1'b0 || ld_ready[sel] !== 1'b1) begin
      errors++;
      $display("FAIL frame_idle dut%0d word=%h: valid=%b busy=%b last=%b out=%b ready=%b, required 0 0 0 0 1",
               sel, w, sv[sel], bz[sel], sl[sel], so[sel], ld_ready[sel]);
    end
  endtask

  task automatic test_back_to_back(input int sel, input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [W-1:0] w;
    int fi;
    @(negedge clk);
    ld_data[sel]  = w0;
    ld_valid[sel] = 1'b1;
    @(negedge clk);
    ld_data[sel] = w1;
    for (int i = 0; i < 2 * FL; i++) begin
      if (i == FL) ld_valid[sel] = 1'b0;
      fi = i % FL;
      w  = (i < FL) ? w0 : w1;
      checks++;
      if (sv[sel] !== 1'b1 || so[sel] !== exp_bit(sel, w, fi) || sl[sel] !== (fi == FL - 1) ||
          ld_ready[sel] !== (fi == FL - 1)) begin
        errors++;
        $display("FAIL b2b_bit dut%0d words=%h,%h cycle%0d: valid=%b out=%b last=%b ready=%b, required 1 %b %b %b",
                 sel, w0, w1, i, sv[sel], so[sel], sl[sel], ld_ready[sel],
                 exp_bit(sel, w, fi), (fi == FL - 1), (fi == FL - 1));
      end
      @(negedge clk);
    end
    checks++;
    if (sv[sel] !== 1'b0 || bz[sel] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle dut%0d: valid=%b busy=%b, required 0 0", sel, sv[sel], bz[sel]);
    end
  endtask

  task automatic test_lsb();
    test_single_frame(0, 8'hA5);
  endtask

  task automatic test_msb();
    test_single_frame(1, 8'h81);
    test_single_frame(1, 8'h40);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    ld_data[0]  = 8'hFF;
    ld_valid[0] = 1'b1;
    @(negedge clk);
    ld_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sv[0] !== 1'b1 || so[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_inflight: valid=%b out=%b, required 1 1", sv[0], so[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sv[0] !== 1'b0 || bz[0] !== 1'b0 || so[0] !== 1'b0 || sl[0] !== 1'b0 || ld_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_drop: valid=%b busy=%b out=%b last=%b ready=%b, required 0 0 0 0 1",
               sv[0], bz[0], so[0], sl[0], ld_ready[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      checks++;
      if (sl[0] !== 1'b0 || sv[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_last cycle%0d: last=%b valid=%b, required 0 0", i, sl[0], sv[0]);
      end
    end
    test_single_frame(0, 8'h01);
  endtask

  task automatic test_parity();
    test_single_frame(0, 8'h07);
    test_single_frame(0, 8'h03);
  endtask

  task automatic test_random();
    int sel;
    logic [W-1:0] w;
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(0, 1));
      w   = W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        test_back_to_back(sel, w, W'($urandom));
      end else begin
        test_single_frame(sel, w);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      ld_valid[s] = 1'b0;
      ld_data[s]  = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_lsb();
    test_msb();
    test_back_to_back(0, 8'h0F, 8'hF0);
    test_back_to_back(1, 8'h0F, 8'hF0);
    test_reset_mid_frame();
    test_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register that accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock with a framing strobe. It is the transmit-side counterpart to the parallel capture registers. It sits between a parallel data source and a single-wire serial link, and its output stream is consumed by a matching serial-in parallel-out receiver.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32
- MSB_FIRST, 0, bit order: 0 shifts out bit 0 first, 1 shifts out bit WIDTH-1 first
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- load_data  input  WIDTH  parallel word to transmit
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a frame bit this cycle
- ser_last  output  1  ser_out is the final bit of the frame
- busy  output  1  a frame is in progress

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits are being sent.
  - PARITY: the parity bit is being sent. This state exists only with PARITY_EN.
- Accept: a word is accepted when load_valid && load_ready are both high at a rising clk edge. On acceptance, the shift register loads load_data, the bit counter is set to 0, and the state becomes SHIFT.
- load_ready = (state == IDLE) || ser_last. It is combinational from registered state only and does not depend on load_valid.
- In SHIFT, ser_out is the current head bit: bit 0 when MSB_FIRST=0, bit WIDTH-1 when MSB_FIRST=1.
  - Each cycle the register shifts toward the head and the counter increments.
  - ser_valid=1 and busy=1.
- Data bits are sent in counter order 0..WIDTH-1.
- ser_last is asserted on counter == WIDTH-1 in SHIFT when parity is off, or in the PARITY state when parity is on.
- After the last bit:
  - If a new word is accepted in the same cycle, the state goes to SHIFT with no idle gap.
  - Otherwise the state goes to IDLE.
- In IDLE, ser_out=0, ser_valid=0, ser_last=0 and busy=0.
- load_data is sampled only on the accept edge. Later changes to load_data do not affect the frame in flight.
- load_valid without load_ready is ignored. The source must hold its word until it is accepted.
- Bit counter width is $clog2(WIDTH+1).

## Timing
- Reset values (immediate, asynchronous):
  - state = IDLE, counter = 0, shift register = 0
  - ser_out = 0, ser_valid = 0, ser_last = 0, busy = 0
  - load_ready = 1
- Loads are ignored while rst_n is low.
- Latency: the first serial bit appears in the cycle after the accept edge.
- Frame length is WIDTH cycles, or WIDTH+1 cycles with parity.
- Throughput: back-to-back words produce a continuous stream with ser_valid held high and no bubbles.
- Reset mid-frame: the frame is discarded, all outputs drop within the same cycle, and there is no partial ser_last. After release, the block accepts a new word normally.
- ser_out, ser_valid, ser_last and busy are registered or derived from registered state only, so there are no combinational paths from inputs.

## Configuration
- PIS0_PARITY_EN is not used. The macro is PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits, captured at accept) is sent in a PARITY state after the last data bit.
  - ser_last moves to the parity bit.
  - Frame length is WIDTH+1.
- Undefined:
  - The PARITY state and parity logic are absent.
  - Frame length is WIDTH.

## Structure
- Shared package serdes_pkg contains:
  - the state enum (IDLE, SHIFT, PARITY)
  - the function computing counter width from WIDTH
  - the localparam for frame length
- One sub-module is natural: bit_counter.
  - It is a loadable up-counter with terminal-count flag.
  - It is parameterised on width and terminal value.
  - It can be reused by the receiver side.

## Test plan
- Reset:
  - Assert rst_n=0 mid-simulation with no clock edge.
  - Required: ser_valid=0, busy=0, ser_out=0, load_ready=1 immediately.
  - Required: load_valid=1 during reset is not accepted.
- LSB-first word: MSB_FIRST=0, load 8'hA5.
  - Required: ser_out=1,0,1,0,0,1,0,1 on cycles 1..8 after accept.
  - Required: ser_last only on cycle 8, then IDLE.
- MSB-first word: MSB_FIRST=1, load 8'h81, then load 8'h40.
  - Required: 1,0,0,0,0,0,0,1 for the first word.
  - Required: 0,1,0,0,0,0,0,0 for the second word.
- Back-to-back: load 8'h0F, keep load_valid=1 with 8'hF0.
  - Required: the second accept occurs on the ser_last cycle.
  - Required: 16 contiguous ser_valid cycles carrying 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1.
- Reset mid-frame: load 8'hFF, pull rst_n low during bit 3, release, then load 8'h01.
  - Required: outputs drop at once and no ser_last occurs for the aborted frame.
  - Required: the new frame is 1,0,0,0,0,0,0,0.
- PISO_PARITY_EN: load 8'h07, then load 8'h03.
  - Required for 8'h07: 8 data bits followed by a 9th bit = 1, with ser_last on bit 9.
  - Required for 8'h03: parity bit = 0.
